// File: rtl/hybrid_adder8_struct.sv
// 8-bit registered adder: the core ripples bits 1:0, does flattened lookahead
// over bits 5:2 and ripples bits 7:6. S and C8 are the only state.
module hybrid_adder8_struct (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] S,
  output logic       C8,
  input  logic [7:0] X,
  input  logic [7:0] Y,
  input  logic       C0
);

  logic [7:0] p;
  logic [7:0] g;
  logic [7:0] cin;
  logic [7:0] sum_d;
  logic       c1, c2, c3, c4, c5, c6, c7, c8_d;
  logic       r0, r1, r6, r7;

  logic [7:0] s_q;
  logic       c8_q;

  genvar i;
  for (i = 0; i < 8; i++) begin : g_bit
    xor u_p (p[i], X[i], Y[i]);
    and u_g (g[i], X[i], Y[i]);
    xor u_s (sum_d[i], p[i], cin[i]);
  end

  assign cin = {c7, c6, c5, c4, c3, c2, c1, C0};

  // Segment A: ripple from C0.
  and u_r0 (r0, p[0], C0);
  or  u_c1 (c1, g[0], r0);
  and u_r1 (r1, p[1], c1);
  or  u_c2 (c2, g[1], r1);

  // Segment B: every carry is a two-level SOP over g, p and c2 only.
  logic t3a;
  logic t4a, t4b;
  logic t5a, t5b, t5c;
  logic t6a, t6b, t6c, t6d;

  and u_t3a (t3a, p[2], c2);
  or  u_c3  (c3, g[2], t3a);

  and u_t4a (t4a, p[3], g[2]);
  and u_t4b (t4b, p[3], p[2], c2);
  or  u_c4  (c4, g[3], t4a, t4b);

  and u_t5a (t5a, p[4], g[3]);
  and u_t5b (t5b, p[4], p[3], g[2]);
  and u_t5c (t5c, p[4], p[3], p[2], c2);
  or  u_c5  (c5, g[4], t5a, t5b, t5c);

  and u_t6a (t6a, p[5], g[4]);
  and u_t6b (t6b, p[5], p[4], g[3]);
  and u_t6c (t6c, p[5], p[4], p[3], g[2]);
  and u_t6d (t6d, p[5], p[4], p[3], p[2], c2);
  or  u_c6  (c6, g[5], t6a, t6b, t6c, t6d);

  // Segment C: ripple from c6.
  and u_r6 (r6, p[6], c6);
  or  u_c7 (c7, g[6], r6);
  and u_r7 (r7, p[7], c7);
  or  u_c8 (c8_d, g[7], r7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= 8'h00;
      c8_q <= 1'b0;
    end else begin
      s_q  <= sum_d;
      c8_q <= c8_d;
    end
  end

  assign S  = s_q;
  assign C8 = c8_q;

endmodule

// File: tb/tb_hybrid_adder8_struct.sv
// Directed and random checks of hybrid_adder8_struct against a 9-bit reference sum.
module tb_hybrid_adder8_struct;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] S;
  logic       C8;
  logic [7:0] X;
  logic [7:0] Y;
  logic       C0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hybrid_adder8_struct dut (
    .clk  (clk),
    .rst_n(rst_n),
    .S    (S),
    .C8   (C8),
    .X    (X),
    .Y    (Y),
    .C0   (C0)
  );

  // Directed vectors: {X, Y, C0} with hand-computed {C8, S}.
  localparam int NVec = 10;
  logic [7:0] vx [NVec] = '{8'h60, 8'hFF, 8'hAA, 8'hAA, 8'h08, 8'h08, 8'h01, 8'hF0, 8'hFF, 8'h00};
  logic [7:0] vy [NVec] = '{8'h7F, 8'hFE, 8'h55, 8'h55, 8'h81, 8'h81, 8'h00, 8'h88, 8'hFF, 8'h00};
  logic       vc [NVec] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
  logic [8:0] ve [NVec] = '{9'h0DF, 9'h1FD, 9'h0FF, 9'h100, 9'h089,
                            9'h08A, 9'h002, 9'h179, 9'h1FF, 9'h000};

  task automatic test_reset();
    rst_n = 1'b0;
    X = 8'hFF; Y = 8'h01; C0 = 1'b1;
    #1;
    n_checks++;
    if ({C8, S} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_initial: got %03h, expected 000", {C8, S});
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({C8, S} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_held_over_edges: got %03h, expected 000", {C8, S});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({C8, S} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_release_no_update: got %03h, expected 000", {C8, S});
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      X = vx[i]; Y = vy[i]; C0 = vc[i];
      @(posedge clk);
      #1;
      n_checks++;
      if ({C8, S} !== ve[i]) begin
        n_fail++;
        $display("FAIL directed_%0d X=%02h Y=%02h C0=%0b: got %03h, expected %03h",
                 i, vx[i], vy[i], vc[i], {C8, S}, ve[i]);
      end
    end
  endtask

  // Same vectors issued on consecutive cycles; each result lands one edge later.
  task automatic test_back_to_back();
    @(negedge clk);
    X = vx[0]; Y = vy[0]; C0 = vc[0];
    for (int i = 1; i <= NVec; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({C8, S} !== ve[i-1]) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: got %03h, expected %03h", i - 1, {C8, S}, ve[i-1]);
      end
      if (i < NVec) begin
        X = vx[i]; Y = vy[i]; C0 = vc[i];
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    X = 8'h60; Y = 8'h7F; C0 = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({C8, S} !== 9'h0DF) begin
      n_fail++;
      $display("FAIL mid_reset_preload: got %03h, expected 0DF", {C8, S});
    end
    X = 8'hF0; Y = 8'h88; C0 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({C8, S} !== 9'h000) begin
      n_fail++;
      $display("FAIL mid_reset_async_clear: got %03h, expected 000", {C8, S});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({C8, S} !== 9'h000) begin
      n_fail++;
      $display("FAIL mid_reset_discard: got %03h, expected 000", {C8, S});
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({C8, S} !== 9'h000) begin
      n_fail++;
      $display("FAIL mid_reset_release_no_update: got %03h, expected 000", {C8, S});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({C8, S} !== 9'h179) begin
      n_fail++;
      $display("FAIL mid_reset_first_edge: got %03h, expected 179", {C8, S});
    end
  endtask

  task automatic test_sweep();
    logic [8:0] exp_q;
    @(negedge clk);
    X = 8'($urandom); Y = 8'($urandom); C0 = 1'($urandom);
    for (int i = 0; i < 4000; i++) begin
      exp_q = {1'b0, X} + {1'b0, Y} + {8'h00, C0};
      @(posedge clk);
      #1;
      n_checks++;
      if ({C8, S} !== exp_q) begin
        n_fail++;
        $display("FAIL sweep_%0d: got %03h, expected %03h", i, {C8, S}, exp_q);
      end
      X = 8'($urandom); Y = 8'($urandom); C0 = 1'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hybrid_adder8_struct.md
HYBRID_ADDER8_STRUCT -- requirements
Module: hybrid_adder8_struct

Interface
REQ-001 The block SHALL have no parameters; the width is fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 S  output  8  registered sum, X + Y + C0 modulo 256.
REQ-005 C8  output  1  registered carry-out of bit 7.
REQ-006 X  input  8  addend, unsigned.
REQ-007 Y  input  8  addend, unsigned.
REQ-008 C0  input  1  carry-in to bit 0.
REQ-009 Port order SHALL be clk, rst_n, S, C8, X, Y, C0.

Function
REQ-010 The combinational core SHALL be a structural hybrid adder in three segments: ripple, lookahead, ripple.
REQ-011 Segment A (bits 1:0) SHALL be two gate-level full adders rippling from C0, producing internal carry c2.
REQ-012 Segment B (bits 5:2) SHALL be a 4-bit carry-lookahead unit with carry-in c2.
REQ-013 Segment B per-bit logic: generate g_i = X_i AND Y_i; propagate p_i = X_i XOR Y_i; sum S_i = p_i XOR c_i.
REQ-014 Segment B SHALL compute c3, c4, c5 and c6 from flattened two-level sum-of-products lookahead equations over g, p and c2 only, with no carry chained between bits.
REQ-015 Segment C (bits 7:6) SHALL be two gate-level full adders rippling from c6; the carry out of bit 7 is the next-state C8.
REQ-016 The core SHALL use gate primitives or gate-level submodules only; no behavioural '+' operator SHALL be used in the datapath.
REQ-017 On each rising clk edge with rst_n high, S and C8 SHALL load the core result from the current X, Y and C0.
REQ-018 Latency SHALL be exactly one clock cycle; a new operand set is accepted every cycle, with no handshake.
REQ-019 The concatenation {C8, S} SHALL equal X + Y + C0 as a 9-bit unsigned sum for all 2^17 input combinations.
REQ-020 Wrap-around: when the sum is 256 or more, S SHALL hold the sum minus 256 and C8 SHALL be 1.
REQ-021 Inputs SHALL NOT be registered; only S and C8 are state.

Reset
REQ-022 While rst_n is low, S SHALL be 8'h00 and C8 SHALL be 0, immediately and independently of clk.
REQ-023 Reset asserted mid-operation SHALL discard the pending result.
REQ-024 The first rising edge after rst_n deasserts SHALL load the result for the inputs present at that edge.
REQ-025 Deassertion of rst_n SHALL NOT itself update S or C8.

Verification
REQ-026 X=0x60, Y=0x7F, C0=0 -> after 1 clk: S=0xDF, C8=0.
REQ-027 X=0xFF, Y=0xFE, C0=0 -> S=0xFD, C8=1; X=0xAA, Y=0x55, C0=0 -> S=0xFF, C8=0.
REQ-028 X=0xAA, Y=0x55, C0=1 -> S=0x00, C8=1, exercising a full propagate chain through all three segments.
REQ-029 X=0x08, Y=0x81 with C0=0 -> S=0x89, C8=0; with C0=1 -> S=0x8A, C8=0.
REQ-030 X=0x01, Y=0x00, C0=1 -> S=0x02, C8=0; X=0xF0, Y=0x88, C0=1 -> S=0x79, C8=1.
REQ-031 Drive rst_n low between clk edges while S is nonzero -> S=0x00 and C8=0 at once; hold inputs through release -> result appears on the first edge after release.
REQ-032 The bench SHALL also run an exhaustive or random sweep of X, Y and C0 against a 9-bit reference sum, checked one cycle later.
